alu_control_muldiv: RTL and testbench
=====================================

ALU_CONTROL_MULDIV -- requirements
Module: alu_control_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be an even value of at least 4.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port ALUOp  input  3  0=ADD, 1=SUB, 2=RFORMAT, 3=AND, 4=OR; 5-7 illegal.
REQ-005 Port Funct  input  6  R-format function field.
REQ-006 Port op_valid  input  1  ALUOp/Funct/operands valid this cycle.
REQ-007 Port src_a, src_b  input  WIDTH each  multiply/divide operands (rs, rt).
REQ-008 Port alucontrol  output  4  ALU select, combinational.
REQ-009 Port jr  output  1  combinational; high iff ALUOp=RFORMAT and Funct=8.
REQ-010 Port illegal  output  1  combinational; unknown ALUOp, or unknown Funct under RFORMAT.
REQ-011 Port stall  output  1  high while a multi-cycle operation is in progress.
REQ-012 Port done  output  1  one-cycle pulse when hi/lo are updated.
REQ-013 Ports hi, lo  output  WIDTH each  HI/LO result registers.

Function
REQ-014 Decode SHALL map: ADD->0010, SUB->0110, AND->0000, OR->0001; under RFORMAT, Funct 32->0010, 34->0110, 36->0000, 37->0001, 39->1100, 42->0111, 41->0100, 0->0011, 2->1011, 24/25->1111, 26/27->1110, 16/18->1101, 8->0000.
REQ-015 Illegal ALUOp or Funct SHALL drive alucontrol=0010 and illegal=1, never X.
REQ-016 FSM states: IDLE, MUL, DIV, FIN; reset state IDLE.
REQ-017 IDLE->MUL on op_valid, RFORMAT, Funct 24 (MULT, signed) or 25 (MULTU); operands latched that edge.
REQ-018 IDLE->DIV on op_valid, RFORMAT, Funct 26 (DIV, signed) or 27 (DIVU); operands latched.
REQ-019 MUL/DIV SHALL iterate radix-2, one bit per cycle, for exactly WIDTH cycles, then enter FIN.
REQ-020 FIN SHALL load hi/lo, pulse done, return to IDLE the next edge; total latency WIDTH+1 cycles from accepting edge to done.
REQ-021 stall SHALL be high in MUL, DIV and FIN, low in IDLE.
REQ-022 Multiply: {hi,lo} = full 2*WIDTH-bit product; signed via magnitudes, sign corrected in FIN.
REQ-023 Divide: lo=quotient, hi=remainder; signed truncates toward zero, remainder takes dividend sign.
REQ-024 Divide by zero: lo=all ones, hi=dividend; same latency, no error flag.
REQ-025 Signed overflow (most-negative / -1): lo=most-negative, hi=0.
REQ-026 MULT/DIV requests arriving while stall=1 SHALL be ignored; upstream holds them.
REQ-027 Single-cycle decodes (incl. MFHI 16, MFLO 18) SHALL remain combinational while stall=1; hi/lo hold previous values until FIN.

Reset
REQ-028 Reset SHALL force IDLE, hi=0, lo=0, done=0, stall=0, iteration counter=0.
REQ-029 Reset mid-operation SHALL abandon the operation; hi/lo SHALL be 0, not partial results.
REQ-030 Reset with op_valid high SHALL NOT start an operation that cycle.

Configuration
REQ-031 Macro ALU_CONTROL_MULDIV_DIV_EN: defined, divider datapath and DIV state built per REQ-018/023-025.
REQ-032 Undefined: no divider logic; Funct 26/27 SHALL decode as illegal (alucontrol 0010, illegal=1) and SHALL NOT start the FSM.

Verification
REQ-033 reset=1 two cycles, then ALUOp=0, ALUOp=1 -> alucontrol 0010, 0110; hi=lo=0, stall=0.
REQ-034 WIDTH=32, MULTU src_a=0xFFFFFFFF, src_b=2 -> done after 33 cycles, hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 MULT src_a=-3, src_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high 33 cycles.
REQ-036 DIV_EN defined: DIV src_a=-7, src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU by 0 with src_a=5 -> lo=0xFFFFFFFF, hi=5.
REQ-037 Reset asserted 10 cycles into MULT -> next cycle IDLE, stall=0, hi=lo=0, no done pulse.
REQ-038 RFORMAT Funct=8 -> jr=1, alucontrol 0000; Funct=63 -> illegal=1, alucontrol 0010; second MULT during stall -> ignored, first result unchanged.

Source files
------------

// File: rtl/alu_control_muldiv_if.sv
// Decode request, multiply/divide operands and HI/LO results of alu_control_muldiv.
interface alu_control_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       ALUOp;
  logic [5:0]       Funct;
  logic             op_valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alucontrol;
  logic             jr;
  logic             illegal;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output ALUOp, Funct, op_valid, src_a, src_b,
    input  alucontrol, jr, illegal, stall, done, hi, lo
  );

  modport slave (
    input  ALUOp, Funct, op_valid, src_a, src_b,
    output alucontrol, jr, illegal, stall, done, hi, lo
  );
endinterface

// File: rtl/alu_control_muldiv.sv
// ALU control decoder plus a radix-2 sequential multiply/divide unit feeding HI/LO.
// Define ALU_CONTROL_MULDIV_DIV_EN to build the divider and accept DIV/DIVU.
module alu_control_muldiv #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  alu_control_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_RFMT = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
`ifdef ALU_CONTROL_MULDIV_DIV_EN
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
`endif
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLTU  = 6'd41;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [3:0]       ctrl;
  logic             jr_dec, illegal_dec;
  logic             is_mul_req, is_div_req, op_signed, a_neg, b_neg, start;
  logic [WIDTH-1:0] acc_hi, acc_lo, opd;
  logic             neg_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
`ifdef ALU_CONTROL_MULDIV_DIV_EN
  logic             neg_r, is_div, div_zero, div_ge;
  logic [WIDTH-1:0] dividend, div_diff;
  logic [WIDTH:0]   div_shift;
`endif

  // Decode is purely combinational and independent of the multiply/divide FSM
  always_comb begin
    ctrl        = 4'b0010;
    jr_dec      = 1'b0;
    illegal_dec = 1'b0;
    case (bus.ALUOp)
      OP_ADD: ctrl = 4'b0010;
      OP_SUB: ctrl = 4'b0110;
      OP_AND: ctrl = 4'b0000;
      OP_OR:  ctrl = 4'b0001;
      OP_RFMT: begin
        case (bus.Funct)
          F_ADD:           ctrl = 4'b0010;
          F_SUB:           ctrl = 4'b0110;
          F_AND:           ctrl = 4'b0000;
          F_OR:            ctrl = 4'b0001;
          F_NOR:           ctrl = 4'b1100;
          F_SLT:           ctrl = 4'b0111;
          F_SLTU:          ctrl = 4'b0100;
          F_SLL:           ctrl = 4'b0011;
          F_SRL:           ctrl = 4'b1011;
          F_MULT, F_MULTU: ctrl = 4'b1111;
`ifdef ALU_CONTROL_MULDIV_DIV_EN
          F_DIV, F_DIVU:   ctrl = 4'b1110;
`endif
          F_MFHI, F_MFLO:  ctrl = 4'b1101;
          F_JR: begin
            ctrl   = 4'b0000;
            jr_dec = 1'b1;
          end
          default:         illegal_dec = 1'b1;
        endcase
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  assign is_mul_req = bus.op_valid && (bus.ALUOp == OP_RFMT) &&
                      (bus.Funct == F_MULT || bus.Funct == F_MULTU);
`ifdef ALU_CONTROL_MULDIV_DIV_EN
  assign is_div_req = bus.op_valid && (bus.ALUOp == OP_RFMT) &&
                      (bus.Funct == F_DIV || bus.Funct == F_DIVU);
`else
  assign is_div_req = 1'b0;
`endif
  // Signed variants have even Funct codes (MULT 24, DIV 26)
  assign op_signed = ~bus.Funct[0];
  assign a_neg     = op_signed & bus.src_a[WIDTH-1];
  assign b_neg     = op_signed & bus.src_b[WIDTH-1];
  assign start     = (state == IDLE) && (is_mul_req || is_div_req);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (is_mul_req)      state_next = MUL;
        else if (is_div_req) state_next = DIV;
      end
      MUL, DIV: if (count == LAST_ITER) state_next = FIN;
      FIN:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Iteration step: shift-add for multiply, restoring subtract for divide
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
`ifdef ALU_CONTROL_MULDIV_DIV_EN
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opd};
  assign div_diff  = div_shift[WIDTH-1:0] - opd;
`endif

  // Operand latch / iteration registers (datapath only, no reset)
  always_ff @(posedge clk) begin
    if (start) begin
      acc_hi <= '0;
      acc_lo <= is_mul_req ? cond_neg(bus.src_b, b_neg) : cond_neg(bus.src_a, a_neg);
      opd    <= is_mul_req ? cond_neg(bus.src_a, a_neg) : cond_neg(bus.src_b, b_neg);
      neg_q  <= a_neg ^ b_neg;
`ifdef ALU_CONTROL_MULDIV_DIV_EN
      neg_r    <= a_neg;
      is_div   <= is_div_req;
      div_zero <= (bus.src_b == '0);
      dividend <= bus.src_a;
`endif
    end else if (state == MUL) begin
      acc_hi <= mul_sum[WIDTH:1];
      acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
`ifdef ALU_CONTROL_MULDIV_DIV_EN
    else if (state == DIV) begin
      acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
      acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
    end
`endif
  end

  // FIN: sign correction of magnitude results and the divide special cases
  always_comb begin
    {res_hi, res_lo} = cond_neg_wide({acc_hi, acc_lo}, neg_q);
`ifdef ALU_CONTROL_MULDIV_DIV_EN
    if (is_div) begin
      if (div_zero) begin
        res_lo = '1;
        res_hi = dividend;
      end else begin
        res_lo = cond_neg(acc_lo, neg_q);
        res_hi = cond_neg(acc_hi, neg_r);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state == FIN);
      count  <= (state == MUL || state == DIV) ? count + CNT_W'(1) : '0;
      if (state == FIN) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.alucontrol = ctrl;
  assign bus.jr         = jr_dec;
  assign bus.illegal    = illegal_dec;
  assign bus.stall      = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed bench for alu_control_muldiv with a transaction-level reference model.
module tb_alu_control_muldiv;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_control_muldiv_if #(.WIDTH(W)) bus();
  alu_control_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode table for R-format Funct codes
  logic [3:0] rtab [int];

  function automatic logic [5:0] exp_dec(input logic [2:0] op, input logic [5:0] f);
    case (op)
      3'd0: return {2'b00, 4'b0010};
      3'd1: return {2'b00, 4'b0110};
      3'd3: return {2'b00, 4'b0000};
      3'd4: return {2'b00, 4'b0001};
      3'd2: begin
        if (rtab.exists(int'(f))) return {1'b0, (f == 6'd8), rtab[int'(f)]};
        return {2'b10, 4'b0010};
      end
      default: return {2'b10, 4'b0010};
    endcase
  endfunction

  function automatic bit starts_fsm(input logic [5:0] f);
`ifdef ALU_CONTROL_MULDIV_DIV_EN
    return (f == 6'd24 || f == 6'd25 || f == 6'd26 || f == 6'd27);
`else
    return (f == 6'd24 || f == 6'd25);
`endif
  endfunction

  // {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (f)
      6'd24: return 64'(sa * sb);
      6'd25: return ua * ub;
      6'd26: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      6'd27: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(ua / ub);
        r = 32'(ua % ub);
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  int          m_busy = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_busy = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_hi   = m_phi;
        m_lo   = m_plo;
        m_done = 1'b1;
      end
    end else if (bus.op_valid && bus.ALUOp == 3'd2 && starts_fsm(bus.Funct)) begin
      {m_phi, m_plo} = model_result(bus.Funct, bus.src_a, bus.src_b);
      m_busy = W + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("decode", {bus.illegal, bus.jr, bus.alucontrol}, exp_dec(bus.ALUOp, bus.Funct));
      check("stall", bus.stall, m_busy > 0);
      check("done", bus.done, m_done);
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp    = 3'd2;
    bus.Funct    = f;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    bus.ALUOp    = 3'd0;
    bus.Funct    = 6'd0;
  endtask

  task automatic wait_done(output int cyc, output int stl);
    cyc = 0;
    stl = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.stall === 1'b1) stl++;
      step();
      cyc++;
    end
  endtask

  int flist[18] = '{0, 1, 2, 8, 16, 18, 24, 25, 26, 27, 32, 34, 36, 37, 39, 41, 42, 63};

  initial begin
    int cyc, stl;
    bit seen;
    rtab[32] = 4'b0010; rtab[34] = 4'b0110; rtab[36] = 4'b0000; rtab[37] = 4'b0001;
    rtab[39] = 4'b1100; rtab[42] = 4'b0111; rtab[41] = 4'b0100; rtab[0]  = 4'b0011;
    rtab[2]  = 4'b1011; rtab[24] = 4'b1111; rtab[25] = 4'b1111; rtab[16] = 4'b1101;
    rtab[18] = 4'b1101; rtab[8]  = 4'b0000;
`ifdef ALU_CONTROL_MULDIV_DIV_EN
    rtab[26] = 4'b1110; rtab[27] = 4'b1110;
`endif
    bus.ALUOp = 3'd0; bus.Funct = 6'd0; bus.op_valid = 1'b0;
    bus.src_a = '0;   bus.src_b = '0;

    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;

    // Reset state and basic decode
    bus.ALUOp = 3'd0;
    #1 check("add_ctrl", bus.alucontrol, 4'b0010);
    bus.ALUOp = 3'd1;
    #1 check("sub_ctrl", bus.alucontrol, 4'b0110);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_stall", bus.stall, 1'b0);
    step();

    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 18; k++) begin
        bus.ALUOp = 3'(op);
        bus.Funct = 6'(flist[k]);
        step();
      end
    end

    bus.ALUOp = 3'd2; bus.Funct = 6'd8;
    #1 check("jr_flag", bus.jr, 1'b1);
    check("jr_ctrl", bus.alucontrol, 4'b0000);
    bus.Funct = 6'd63;
    #1 check("f63_illegal", bus.illegal, 1'b1);
    check("f63_ctrl", bus.alucontrol, 4'b0010);
    bus.ALUOp = 3'd5;
    #1 check("op5_illegal", bus.illegal, 1'b1);
    step();

    // MULTU 0xFFFFFFFF * 2
    issue(6'd25, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc, stl);
    check("multu_latency", 32'(cyc), 32'd33);
    check("multu_hi", bus.hi, 32'h0000_0001);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);
    step();

    // MULT -3 * 7
    issue(6'd24, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, stl);
    check("mult_stall_cycles", 32'(stl), 32'd33);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFEB);
    step();

    // Second MULT while stalled is ignored; MFHI decodes during stall
    issue(6'd24, 32'd5, 32'hFFFF_FFFA);
    repeat (4) step();
    bus.ALUOp = 3'd2; bus.Funct = 6'd25;
    bus.src_a = 32'h1234_5678; bus.src_b = 32'h0000_0100; bus.op_valid = 1'b1;
    repeat (3) step();
    bus.op_valid = 1'b0; bus.Funct = 6'd16;
    #1 check("mfhi_during_stall", bus.alucontrol, 4'b1101);
    check("hi_held_in_stall", bus.hi, 32'hFFFF_FFFF);
    wait_done(cyc, stl);
    check("mult2_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult2_lo", bus.lo, 32'hFFFF_FFE2);
    bus.ALUOp = 3'd0; bus.Funct = 6'd0;
    step();
    check("second_op_ignored", bus.stall, 1'b0);

    // Model-only operand corners
    issue(6'd24, 32'h8000_0000, 32'h8000_0000); wait_done(cyc, stl); step();
    issue(6'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(cyc, stl); step();
    issue(6'd25, 32'h1234_5678, 32'h9ABC_DEF0); wait_done(cyc, stl); step();
    issue(6'd24, 32'h7FFF_FFFF, 32'h8000_0000); wait_done(cyc, stl); step();

`ifdef ALU_CONTROL_MULDIV_DIV_EN
    issue(6'd26, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, stl);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    step();
    issue(6'd27, 32'd5, 32'd0);
    wait_done(cyc, stl);
    check("divu0_latency", 32'(cyc), 32'd33);
    check("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    check("divu0_hi", bus.hi, 32'd5);
    step();
    issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, stl);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'd0);
    step();
    issue(6'd26, 32'hFFFF_FFF9, 32'd0); wait_done(cyc, stl); step();
    issue(6'd27, 32'd100, 32'd7);       wait_done(cyc, stl); step();
    issue(6'd26, 32'd100, 32'hFFFF_FFF9); wait_done(cyc, stl); step();
`else
    bus.ALUOp = 3'd2; bus.Funct = 6'd26;
    #1 check("div_illegal", bus.illegal, 1'b1);
    check("div_illegal_ctrl", bus.alucontrol, 4'b0010);
    issue(6'd27, 32'd5, 32'd0);
    check("div_no_start", bus.stall, 1'b0);
    step();
`endif

    // Reset 10 cycles into MULT, with a new MULT presented during reset
    issue(6'd24, 32'd1234, 32'd5678);
    repeat (9) step();
    reset = 1'b1;
    bus.ALUOp = 3'd2; bus.Funct = 6'd24; bus.op_valid = 1'b1;
    bus.src_a = 32'd9; bus.src_b = 32'd9;
    step();
    check("rst_mid_stall", bus.stall, 1'b0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    reset = 1'b0;
    bus.op_valid = 1'b0; bus.ALUOp = 3'd0; bus.Funct = 6'd0;
    seen = 1'b0;
    repeat (40) begin
      if (bus.done === 1'b1) seen = 1'b1;
      step();
    end
    check("rst_mid_no_done", seen, 1'b0);

    issue(6'd25, 32'd3, 32'd4);
    wait_done(cyc, stl);
    check("post_reset_lo", bus.lo, 32'd12);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
